// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_pkg
//  Description : Shared definitions for the 4x4 keypad scanner: FSM state
//                encoding, idle column drive, key_code field layout and the
//                row-priority / code-packing helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_scanner_pkg;

    // Scanner FSM states
    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;

    // Column drive after reset: column 0 selected (active-low)
    localparam logic [3:0] COL_IDLE = 4'b1110;

    // key_code = {row_idx, col_idx}
    localparam int ROW_MSB = 3;
    localparam int ROW_LSB = 2;
    localparam int COL_MSB = 1;
    localparam int COL_LSB = 0;

    // Fixed priority: the lowest-numbered low row wins. Only meaningful when
    // at least one row is low; returns 3 otherwise.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] pack_code(input logic [1:0] row_idx,
                                             input logic [1:0] col_idx);
        logic [3:0] code;
        code                  = 4'd0;
        code[ROW_MSB:ROW_LSB] = row_idx;
        code[COL_MSB:COL_LSB] = col_idx;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for asynchronous level inputs.
//                Flops reset to all-ones so idle (pulled-up, active-low)
//                lines read as inactive while reset is held.
//  Ports       : clk   - destination clock
//                rst_n - asynchronous active-low reset
//                d     - asynchronous input bus
//                q     - synchronized output bus (2 clk latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 scanned-matrix keypad reader. Drives one active-low
//                column at a time, samples the synchronized active-low rows
//                at the end of each column dwell, debounces press and
//                release, and reports the accepted key.
//  Ports       : clk       - system clock
//                rst_n     - asynchronous active-low reset
//                io_col    - column drive, active-low, one bit low
//                io_row    - row returns, active-low, asynchronous
//                key_code  - {row_idx, col_idx} of last accepted key
//                key_valid - one-cycle strobe on press acceptance
//                key_held  - high from acceptance until debounced release
//  Params      : SCAN_DIV       - clk cycles per column dwell (>= 4)
//                DEBOUNCE_SCANS - matching samples to accept (>= 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] io_col,
    input  logic [3:0] io_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW_W = $clog2(SCAN_DIV);
    localparam int DB_W = $clog2(DEBOUNCE_SCANS);

    localparam logic [DW_W-1:0] c_dwell_last = DW_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] c_scans_last = DB_W'(DEBOUNCE_SCANS - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [DW_W-1:0] r_dwell;
    logic [1:0]      r_col_idx;
    logic [3:0]      r_col;
    logic [3:0]      r_cand_code;
    logic [DB_W-1:0] r_deb_cnt;
    logic [DB_W-1:0] r_rel_cnt;
    logic [3:0]      r_key_code;
    logic            r_key_valid;
    logic            r_key_held;

    // ------------------------------------------------------------------------
    // Row synchronization and decode
    // ------------------------------------------------------------------------
    logic [3:0] w_row_s;
    logic       w_sample;
    logic       w_pressed;
    logic [1:0] w_row_idx;
    logic [3:0] w_code;
    logic       w_match;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (io_row),
        .q     (w_row_s)
    );

    // Sampling at the end of the dwell gives the column drive, the external
    // matrix and the two synchronizer stages time to settle after a change.
    assign w_sample  = (r_dwell == c_dwell_last);
    assign w_pressed = ~(&w_row_s);
    assign w_row_idx = lowest_low_row(w_row_s);
    assign w_code    = pack_code(w_row_idx, r_col_idx);
    assign w_match   = w_pressed && (w_code == r_cand_code);

    // ------------------------------------------------------------------------
    // Dwell counter: free-running, the only timing source of the scanner
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Scan / debounce / hold FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_col_idx   <= 2'd0;
            r_col       <= COL_IDLE;
            r_cand_code <= 4'd0;
            r_deb_cnt   <= '0;
            r_rel_cnt   <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;

            if (w_sample) begin
                case (r_state)
                    SCAN: begin
                        if (w_pressed) begin
                            // Column stays locked while the key is qualified
                            r_cand_code <= w_code;
                            r_deb_cnt   <= '0;
                            r_state     <= DEBOUNCE;
                        end else begin
                            r_col_idx <= r_col_idx + 2'd1;
                            r_col     <= {r_col[2:0], r_col[3]};
                        end
                    end

                    DEBOUNCE: begin
                        if (w_match) begin
                            if (r_deb_cnt == c_scans_last) begin
                                r_key_code  <= r_cand_code;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_rel_cnt   <= '0;
                                r_state     <= PRESSED;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + 1'b1;
                            end
                        end else begin
                            // Bounce, release or a different winning row:
                            // abandon and move on to the next column.
                            r_state   <= SCAN;
                            r_col_idx <= r_col_idx + 2'd1;
                            r_col     <= {r_col[2:0], r_col[3]};
                        end
                    end

                    PRESSED: begin
                        if (w_pressed) begin
                            // Any key on the locked column keeps it held
                            r_rel_cnt <= '0;
                        end else if (r_rel_cnt == c_scans_last) begin
                            r_key_held <= 1'b0;
                            r_rel_cnt  <= '0;
                            r_state    <= SCAN;
                            r_col_idx  <= r_col_idx + 2'd1;
                            r_col      <= {r_col[2:0], r_col[3]};
                        end else begin
                            r_rel_cnt <= r_rel_cnt + 1'b1;
                        end
                    end

                    default: begin
                        r_state <= SCAN;
                    end
                endcase
            end
        end
    end

    assign io_col    = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//                DEBOUNCE_SCANS=3). A keypad model turns a 16-bit mask of
//                pressed keys (bit = row*4+col) into row returns for the
//                currently driven column.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] io_col;
    logic [3:0] io_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] mask = 16'h0000;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int cyc = 0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_col    (io_col),
        .io_row    (io_row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix model: a row is pulled low when a pressed key joins it
    // to the driven (low) column.
    always_comb begin
        io_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!io_col[c] && mask[r*4+c]) io_row[r] = 1'b0;
            end
        end
    end

    // Clock edges since reset release; sample edges are every 4th one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) pulses++;
    end

    function automatic logic [15:0] key(input int r, input int c);
        logic [15:0] m;
        m = 16'h0000;
        m[r*4+c] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Move to just after the next falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Move to just after the falling edge following the next sample edge
    task automatic to_sample();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cyc % 4 == 0) break;
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] mask;
        int          cycles;
        int          exp_held;
        int          exp_code;
        int          exp_pulses;
        int          max_lat;   // 0 = latency not checked
    } vec_t;

    vec_t vecs[6];

    initial begin
        int p0;
        int lat;
        logic [3:0] exp_col;
        logic found;

        vecs[0] = '{"press_r2c1",    key(2,1),                     40, 1, 4'h9, 1, 30};
        vecs[1] = '{"release_r2c1",  16'h0000,                     40, 0, 4'h9, 0, 0};
        vecs[2] = '{"prio_r1r3c0",   key(1,0) | key(3,0),          40, 1, 4'h4, 1, 30};
        vecs[3] = '{"lock_ignore",   key(1,0) | key(3,0) | key(0,3), 40, 1, 4'h4, 0, 0};
        vecs[4] = '{"next_r0c3",     key(0,3),                     70, 1, 4'h3, 1, 0};
        vecs[5] = '{"release_r0c3",  16'h0000,                     40, 0, 4'h3, 0, 0};

        // ---------------- reset and column rotation ----------------
        repeat (3) tick();
        chk("rst_col",   int'(io_col),    4'b1110);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held",  int'(key_held),  0);
        chk("rst_code",  int'(key_code),  0);
        rst_n = 1'b1;

        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (io_col == 4'b1011) found = 1'b1;
        end
        chk("reach_col2", int'(found), 1);
        #1 rst_n = 1'b0;     // asynchronously, away from any clock edge
        #1;
        chk("async_rst_col",  int'(io_col),   4'b1110);
        chk("async_rst_held", int'(key_held), 0);
        tick();
        tick();
        rst_n = 1'b1;

        exp_col = 4'b1110;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == 3) chk("rot_hold_c0", int'(io_col), 4'b1110);
            if (n % 4 == 0) begin
                exp_col = {exp_col[2:0], exp_col[3]};
                chk($sformatf("rot_step%0d", n / 4), int'(io_col), int'(exp_col));
            end
        end

        // ---------------- table-driven phases ----------------
        for (int v = 0; v < 6; v++) begin
            p0   = pulses;
            lat  = 0;
            mask = vecs[v].mask;
            for (int n = 1; n <= vecs[v].cycles; n++) begin
                tick();
                if (lat == 0 && pulses != p0) lat = n;
            end
            chk({vecs[v].name, "_pulses"}, pulses - p0,  vecs[v].exp_pulses);
            chk({vecs[v].name, "_held"},   int'(key_held), vecs[v].exp_held);
            chk({vecs[v].name, "_code"},   int'(key_code), vecs[v].exp_code);
            if (vecs[v].max_lat != 0)
                chk({vecs[v].name, "_lat_ok"}, int'(lat > 0 && lat <= vecs[v].max_lat), 1);
        end

        // ---------------- bounce during debounce ----------------
        mask = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            to_sample();
            if (io_col == 4'b1101) break;
        end
        chk("bounce_align", int'(io_col), 4'b1101);
        p0   = pulses;
        mask = key(2,1);
        to_sample();                        // detected in SCAN, column locks
        chk("bounce_lock", int'(io_col), 4'b1101);
        mask = 16'h0000;
        to_sample();                        // miss -> scanning resumes
        chk("bounce_resume", int'(io_col), 4'b1011);
        mask = key(2,1);
        for (int i = 0; i < 8; i++) begin
            to_sample();
            if (io_col == 4'b1101) break;
        end
        to_sample();                        // detect again
        to_sample();                        // match 1
        to_sample();                        // match 2
        chk("bounce_no_early", pulses - p0, 0);
        to_sample();                        // match 3 -> accept
        chk("bounce_pulse", pulses - p0, 1);
        chk("bounce_held",  int'(key_held), 1);
        chk("bounce_code",  int'(key_code), 4'h9);

        // ---------------- release debounce ----------------
        p0   = pulses;
        mask = 16'h0000;
        to_sample();
        to_sample();
        chk("rel_partial_held", int'(key_held), 1);
        mask = key(2,1);
        to_sample();                        // re-press clears the release count
        mask = 16'h0000;
        to_sample();
        to_sample();
        chk("rel_restart_held", int'(key_held), 1);
        to_sample();
        chk("rel_done_held", int'(key_held), 0);
        chk("rel_col_adv",   int'(io_col),   4'b1011);
        chk("rel_no_pulse",  pulses - p0,    0);

        // ---------------- reset while held ----------------
        mask  = key(2,1);
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick();
            if (key_held) found = 1'b1;
        end
        chk("mid_hold_reach", int'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_held",  int'(key_held),  0);
        chk("mid_rst_valid", int'(key_valid), 0);
        chk("mid_rst_code",  int'(key_code),  0);
        chk("mid_rst_col",   int'(io_col),    4'b1110);
        tick();
        tick();
        p0    = pulses;
        rst_n = 1'b1;
        for (int n = 0; n < 14; n++) tick();
        chk("mid_rst_no_early", pulses - p0, 0);
        for (int n = 0; n < 40; n++) tick();
        chk("mid_rst_reaccept", pulses - p0, 1);
        chk("mid_rst_reheld",   int'(key_held), 1);
        chk("mid_rst_recode",   int'(key_code), 4'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
